// File: rtl/ifm_win_pkg.sv
// Shared constants and elaboration-time helpers for the IFM window buffer.
package ifm_win_pkg;

  localparam int unsigned IfmDataW = 8;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned k, input int unsigned dw);
    return (r * k + c) * dw;
  endfunction

endpackage

// File: rtl/ifm_line_mem.sv
// One image-row delay: read the previous row's pixel at addr_i, overwrite it on we_i.
module ifm_line_mem
  import ifm_win_pkg::*;
#(
  parameter int unsigned DataW = IfmDataW,
  parameter int unsigned Depth = 32,
  parameter int unsigned AddrW = clog2(Depth)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [DataW-1:0] wr_data_i,
  output logic [DataW-1:0] rd_data_o
);

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/ifm_win_buf.sv
// Raster-scan pixel stream to K x K sliding window with valid/ready output.
// Define IFM_WIN_STRIDE_EN to add the stride2 input (stride-2 window qualification).
module ifm_win_buf
  import ifm_win_pkg::*;
#(
  parameter int unsigned DATA_W = IfmDataW,
  parameter int unsigned K      = 3,
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
`ifdef IFM_WIN_STRIDE_EN
  input  logic                     stride2,
`endif
  output logic                     in_ready,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [K*K*DATA_W-1:0]    win_data,
  output logic                     frame_done
);

  localparam int unsigned ColW = clog2(IMG_W);
  localparam int unsigned RowW = clog2(IMG_H);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0] ColWin  = ColW'(K - 1);
  localparam logic [RowW-1:0] RowWin  = RowW'(K - 1);

  logic            accept;
  logic [ColW-1:0] col_q, col_d, col_cur;
  logic [RowW-1:0] row_q, row_d, row_cur;
  logic            win_valid_q, win_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            win_qual;

  logic [DATA_W-1:0] lm_in   [K-1];
  logic [DATA_W-1:0] lm_out  [K-1];
  logic [DATA_W-1:0] new_col [K];
  logic [DATA_W-1:0] win_q   [K][K];
  logic [DATA_W-1:0] win_d   [K][K];

  assign in_ready = !win_valid_q || win_ready;
  assign accept   = in_valid && in_ready;

  // A pixel accepted together with frame_start is treated as position (0,0).
  assign col_cur = frame_start ? '0 : col_q;
  assign row_cur = frame_start ? '0 : row_q;

  for (genvar j = 0; j < K - 1; j++) begin : g_line
    if (j == 0) begin : g_head
      assign lm_in[j] = in_data;
    end else begin : g_tail
      assign lm_in[j] = lm_out[j-1];
    end
    ifm_line_mem #(
      .DataW (DATA_W),
      .Depth (IMG_W),
      .AddrW (ColW)
    ) u_line (
      .clk       (clk),
      .we_i      (accept),
      .addr_i    (col_cur),
      .wr_data_i (lm_in[j]),
      .rd_data_o (lm_out[j])
    );
  end

  // Delay 0 holds the previous row, so it feeds the second-newest window row.
  assign new_col[K-1] = in_data;
  for (genvar r = 0; r < K - 1; r++) begin : g_col
    assign new_col[r] = lm_out[K-2-r];
  end

`ifdef IFM_WIN_STRIDE_EN
  localparam logic OffPar = 1'((K - 1) % 2);
  assign win_qual = (row_cur >= RowWin) && (col_cur >= ColWin) &&
                    (!stride2 || ((row_cur[0] == OffPar) && (col_cur[0] == OffPar)));
`else
  assign win_qual = (row_cur >= RowWin) && (col_cur >= ColWin);
`endif

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_cur == ColLast) begin
        col_d = '0;
        row_d = (row_cur == RowLast) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
    end else if (frame_start) begin
      col_d = '0;
      row_d = '0;
    end

    win_valid_d = win_valid_q;
    if (accept && win_qual) win_valid_d = 1'b1;
    else if (win_ready)     win_valid_d = 1'b0;

    frame_done_d = accept && (row_cur == RowLast) && (col_cur == ColLast);

    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][K-1] = new_col[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_out_r
    for (genvar c = 0; c < K; c++) begin : g_out_c
      assign win_data[win_idx(r, c, K, DATA_W) +: DATA_W] = win_q[r][c];
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ifm_win_buf.sv
// Directed bench for ifm_win_buf: 4x4 instance for stream/handshake cases, 5x5 for masking/stride.
module tb_ifm_win_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, fs, iv, ir, wv, wr, fd;
  logic [7:0]  idat;
  logic [71:0] wd;
  logic        iv5, ir5, wv5, wr5, fd5;
  logic [7:0]  idat5;
  logic [71:0] wd5;
`ifdef IFM_WIN_STRIDE_EN
  logic        str;
`endif

  int errors = 0;
  int checks = 0;

  int          wpix[$];
  logic [71:0] wdat[$];
  int          n_fd, fd_pix;
  bit          feed_ok;

  ifm_win_buf #(.DATA_W(8), .K(3), .IMG_W(4), .IMG_H(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (fs),
    .in_valid    (iv),
    .in_data     (idat),
`ifdef IFM_WIN_STRIDE_EN
    .stride2     (1'b0),
`endif
    .in_ready    (ir),
    .win_valid   (wv),
    .win_ready   (wr),
    .win_data    (wd),
    .frame_done  (fd)
  );

  ifm_win_buf #(.DATA_W(8), .K(3), .IMG_W(5), .IMG_H(5)) dut5 (
    .clk         (clk),
    .rst         (rst),
    .frame_start (1'b0),
    .in_valid    (iv5),
    .in_data     (idat5),
`ifdef IFM_WIN_STRIDE_EN
    .stride2     (str),
`endif
    .in_ready    (ir5),
    .win_valid   (wv5),
    .win_ready   (wr5),
    .win_data    (wd5),
    .frame_done  (fd5)
  );

  // Expected 3x3 window whose newest pixel sits at (r,c); pixel value = row*w + col.
  function automatic logic [71:0] exp_win(input int r, input int c, input int w);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        v[(i*3+j)*8 +: 8] = 8'((r - 2 + i) * w + (c - 2 + j));
      end
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fs = 1'b0; iv = 1'b0; iv5 = 1'b0; wr = 1'b1; wr5 = 1'b1;
    idat = '0; idat5 = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Streams npix pixels (values first, first+1, ... mod 16) into the 4x4 instance, recording
  // each window with the index of the pixel accepted on the preceding edge.
  task automatic feed4(input int npix, input int first, input bit with_fs);
    int sent, cur;
    bit acc;
    wpix.delete(); wdat.delete();
    n_fd = 0; fd_pix = -1; feed_ok = 0; sent = 0;
    wr = 1'b1; iv = 1'b1; idat = 8'(first); fs = with_fs;
    #1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (sent == npix) iv = 1'b0;
      acc = iv && ir;
      tick();
      fs = 1'b0;
      cur = -1;
      if (acc) begin
        cur = (first + sent) % 16;
        sent++;
        idat = 8'((first + sent) % 16);
      end
      if (wv) begin wpix.push_back(cur); wdat.push_back(wd); end
      if (fd) begin n_fd++; fd_pix = cur; end
      if (sent == npix && !acc) begin feed_ok = 1; break; end
    end
    iv = 1'b0;
  endtask

  task automatic feed5(input int npix);
    int sent, cur;
    bit acc;
    wpix.delete(); wdat.delete();
    feed_ok = 0; sent = 0;
    wr5 = 1'b1; iv5 = 1'b1; idat5 = '0;
    #1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (sent == npix) iv5 = 1'b0;
      acc = iv5 && ir5;
      tick();
      cur = -1;
      if (acc) begin
        cur = sent;
        sent++;
        idat5 = 8'(sent);
      end
      if (wv5) begin wpix.push_back(cur); wdat.push_back(wd5); end
      if (sent == npix && !acc) begin feed_ok = 1; break; end
    end
    iv5 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ir !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ir); end
    checks++; if (wv !== 1'b0) begin errors++; $display("FAIL reset_win_valid: got %b want 0", wv); end
    checks++; if (wd !== 72'h0) begin errors++; $display("FAIL reset_win_data: got %h want 0", wd); end
    checks++; if (fd !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", fd); end
    checks++; if (wv5 !== 1'b0 || wd5 !== 72'h0) begin
      errors++; $display("FAIL reset_dut5: got valid=%b data=%h want 0/0", wv5, wd5);
    end
    tick();
    checks++; if (wv !== 1'b0) begin errors++; $display("FAIL idle_win_valid: got %b want 0", wv); end
  endtask

  task automatic test_first_window();
    do_reset();
    feed4(16, 0, 1'b0);
    checks++; if (!feed_ok) begin errors++; $display("FAIL warmup_timeout: got 0 want 1"); end
    checks++;
    if (wpix.size() == 0) begin
      errors++; $display("FAIL warmup_first: got no window want window after pixel 10");
    end else if (wpix[0] != 10 || wdat[0] !== exp_win(2, 2, 4)) begin
      errors++;
      $display("FAIL warmup_first: got pix=%0d data=%h want pix=10 data=%h",
               wpix[0], wdat[0], exp_win(2, 2, 4));
    end
  endtask

  task automatic test_full_frame();
    int exp_p[4] = '{10, 11, 14, 15};
    feed4(16, 0, 1'b0);
    checks++; if (!feed_ok) begin errors++; $display("FAIL frame_timeout: got 0 want 1"); end
    checks++; if (wpix.size() != 4) begin
      errors++; $display("FAIL frame_count: got %0d want 4", wpix.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= wpix.size()) begin
        errors++; $display("FAIL frame_win%0d: got missing want pix=%0d", k, exp_p[k]);
      end else if (wpix[k] != exp_p[k] || wdat[k] !== exp_win(exp_p[k] / 4, exp_p[k] % 4, 4)) begin
        errors++;
        $display("FAIL frame_win%0d: got pix=%0d data=%h want pix=%0d data=%h", k, wpix[k],
                 wdat[k], exp_p[k], exp_win(exp_p[k] / 4, exp_p[k] % 4, 4));
      end
    end
    checks++; if (n_fd != 1 || fd_pix != 15) begin
      errors++; $display("FAIL frame_done: got count=%0d at=%0d want count=1 at=15", n_fd, fd_pix);
    end
  endtask

  task automatic test_backpressure();
    int sent, n_hs;
    bit acc, hs, stalled, done;
    logic [71:0] held;
    int exp_p[4] = '{10, 11, 14, 15};
    sent = 0; n_hs = 0; stalled = 0; done = 0;
    wr = 1'b1; iv = 1'b1; idat = '0;
    #1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (sent == 16) iv = 1'b0;
      if (wv && !stalled) begin
        stalled = 1; held = wd; wr = 1'b0;
        #1;
        checks++; if (held !== exp_win(2, 2, 4)) begin
          errors++; $display("FAIL bp_stall_win: got %h want %h", held, exp_win(2, 2, 4));
        end
        for (int s = 0; s < 5; s++) begin
          checks++; if (ir !== 1'b0 || wv !== 1'b1) begin
            errors++; $display("FAIL bp_ready%0d: got in_ready=%b win_valid=%b want 0/1", s, ir, wv);
          end
          checks++; if (wd !== held) begin
            errors++; $display("FAIL bp_hold%0d: got %h want %h", s, wd, held);
          end
          tick();
        end
        wr = 1'b1;
        #1;
      end
      acc = iv && ir;
      hs  = wv && wr;
      if (hs) begin
        checks++;
        if (n_hs >= 4) begin
          errors++; $display("FAIL bp_extra: got window %0d want 4 windows", n_hs + 1);
        end else if (wd !== exp_win(exp_p[n_hs] / 4, exp_p[n_hs] % 4, 4)) begin
          errors++; $display("FAIL bp_win%0d: got %h want %h", n_hs, wd,
                             exp_win(exp_p[n_hs] / 4, exp_p[n_hs] % 4, 4));
        end
        n_hs++;
      end
      tick();
      if (acc) begin sent++; idat = 8'(sent); end
      if (sent == 16 && !wv) begin done = 1; break; end
    end
    iv = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL bp_timeout: got 0 want 1"); end
    checks++; if (n_hs != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", n_hs); end
  endtask

  task automatic test_rst_mid();
    feed4(10, 0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (wv !== 1'b0 || wd !== 72'h0) begin
      errors++; $display("FAIL rst_mid_clear: got valid=%b data=%h want 0/0", wv, wd);
    end
    feed4(16, 0, 1'b0);
    checks++;
    if (wpix.size() != 4) begin
      errors++; $display("FAIL rst_mid_count: got %0d want 4", wpix.size());
    end else if (wpix[0] != 10 || wdat[0] !== exp_win(2, 2, 4)) begin
      errors++; $display("FAIL rst_mid_first: got pix=%0d data=%h want pix=10 data=%h",
                         wpix[0], wdat[0], exp_win(2, 2, 4));
    end
  endtask

  task automatic test_frame_start_mid();
    feed4(10, 0, 1'b0);
    feed4(16, 0, 1'b1);
    checks++;
    if (wpix.size() != 4) begin
      errors++; $display("FAIL fs_mid_count: got %0d want 4", wpix.size());
    end else if (wpix[0] != 10 || wdat[0] !== exp_win(2, 2, 4)) begin
      errors++; $display("FAIL fs_mid_first: got pix=%0d data=%h want pix=10 data=%h",
                         wpix[0], wdat[0], exp_win(2, 2, 4));
    end
    checks++; if (n_fd != 1 || fd_pix != 15) begin
      errors++; $display("FAIL fs_mid_done: got count=%0d at=%0d want count=1 at=15", n_fd, fd_pix);
    end
  endtask

  task automatic test_row_mask();
    int k;
`ifdef IFM_WIN_STRIDE_EN
    str = 1'b0;
`endif
    do_reset();
    feed5(25);
    checks++; if (!feed_ok || wpix.size() != 9) begin
      errors++; $display("FAIL mask_count: got %0d want 9", wpix.size());
    end
    for (int r = 2; r < 5; r++) begin
      for (int c = 2; c < 5; c++) begin
        k = (r - 2) * 3 + (c - 2);
        checks++;
        if (k >= wpix.size()) begin
          errors++; $display("FAIL mask_win%0d: got missing want pix=%0d", k, r * 5 + c);
        end else if (wpix[k] != r * 5 + c || wdat[k] !== exp_win(r, c, 5)) begin
          errors++; $display("FAIL mask_win%0d: got pix=%0d data=%h want pix=%0d data=%h", k,
                             wpix[k], wdat[k], r * 5 + c, exp_win(r, c, 5));
        end
      end
    end
  endtask

`ifdef IFM_WIN_STRIDE_EN
  task automatic test_stride();
    int exp_p[4] = '{12, 14, 22, 24};
    str = 1'b1;
    do_reset();
    feed5(25);
    checks++; if (!feed_ok || wpix.size() != 4) begin
      errors++; $display("FAIL stride_count: got %0d want 4", wpix.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= wpix.size()) begin
        errors++; $display("FAIL stride_win%0d: got missing want pix=%0d", k, exp_p[k]);
      end else if (wpix[k] != exp_p[k] || wdat[k] !== exp_win(exp_p[k] / 5, exp_p[k] % 5, 5)) begin
        errors++; $display("FAIL stride_win%0d: got pix=%0d data=%h want pix=%0d data=%h", k,
                           wpix[k], wdat[k], exp_p[k], exp_win(exp_p[k] / 5, exp_p[k] % 5, 5));
      end
    end
    str = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef IFM_WIN_STRIDE_EN
    str = 1'b0;
`endif
    test_reset();
    test_first_window();
    test_full_frame();
    test_backpressure();
    test_rst_mid();
    test_frame_start_mid();
    test_row_mask();
`ifdef IFM_WIN_STRIDE_EN
    test_stride();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
